// File: rtl/machine_pkg.sv
// Shared constants and helpers for the machine_* family of serial detectors.
package machine_pkg;

  localparam int              DEF_PAT_W   = 4;
  localparam logic [3:0]      DEF_PATTERN = 4'b1011;
  localparam int              DEF_CNT_W   = 8;

  // Width needed to hold a state value in 0..n inclusive.
  function automatic int state_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage : machine_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + 1'b1;
    end
  end

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) q_q <= '0;
    else          q_q <= q_d;
  end

  assign q = q_q;

endmodule : sat_counter

// File: rtl/machine_seq.sv
// Serial pattern detector with KMP state tracking, Moore match flag and a
// saturating match counter.
module machine_seq
  import machine_pkg::*;
#(
  parameter int                 PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0]   PATTERN = DEF_PATTERN,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = DEF_CNT_W,
  localparam int                SW      = state_width(PAT_W)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             CLR,
  input  logic             EN,
  input  logic             x,
  output logic             F,
  output logic [SW-1:0]    S,
  output logic [CNT_W-1:0] CNT
);

  localparam logic [SW-1:0] FULL = SW'(PAT_W);

  logic [SW-1:0]    s_q, s_d;
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [PAT_W-1:0] hist_new;
  logic [SW-1:0]    match_len;
  logic             ok;
  int               limit;

  // The longest match can grow by at most one bit per consumed sample, so
  // candidates are capped at S+1; this keeps stale history bits (from before
  // a clear or non-overlap restart) from ever being compared.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    hist_new  = {hist_q, x};
    match_len = '0;
    ok        = 1'b0;
    if ((s_q == FULL) && !OVERLAP) limit = 1;
    else if (s_q == FULL)          limit = PAT_W;
    else                           limit = int'(s_q) + 1;
    for (int k = 1; k <= PAT_W; k++) begin
      ok = (k <= limit);
      for (int j = 0; j < k; j++) begin
        if (hist_new[j] != PATTERN[PAT_W-k+j]) ok = 1'b0;
      end
      if (ok) match_len = SW'(k);
    end
  end

  always_comb begin
    s_d    = s_q;
    hist_d = hist_q;
    if (CLR) begin
      s_d    = '0;
      hist_d = '0;
    end else if (EN) begin
      s_d    = match_len;
      hist_d = hist_new[PAT_W-2:0];
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s_q    <= '0;
      hist_q <= '0;
    end else begin
      s_q    <= s_d;
      hist_q <= hist_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .clr     (CLR),
    .inc     (EN && !CLR && (match_len == FULL)),
    .q       (CNT)
  );

  assign S = s_q;
  assign F = (s_q == FULL);

endmodule : machine_seq

// File: tb/tb_machine_seq.sv
// Directed bench: default overlapping detector, a non-overlapping twin and a
// narrow-counter 1111 detector share clock, reset, clear and enable.
module tb_machine_seq;

  logic       clk = 1'b0;
  logic       rst_n, clr, en, x, x2;
  logic       f0, f1, f2;
  logic [2:0] s0, s1, s2;
  logic [7:0] c0, c1;
  logic [1:0] c2;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  machine_seq u0 (
    .CLK(clk), .RESET_N(rst_n), .CLR(clr), .EN(en), .x(x),
    .F(f0), .S(s0), .CNT(c0)
  );

  machine_seq #(.OVERLAP(1'b0)) u1 (
    .CLK(clk), .RESET_N(rst_n), .CLR(clr), .EN(en), .x(x),
    .F(f1), .S(s1), .CNT(c1)
  );

  machine_seq #(.PAT_W(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(2)) u2 (
    .CLK(clk), .RESET_N(rst_n), .CLR(clr), .EN(en), .x(x2),
    .F(f2), .S(s2), .CNT(c2)
  );

  // Drive on the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic xv, input logic env, input logic clrv);
    @(negedge clk);
    x   = xv;
    x2  = xv;
    en  = env;
    clr = clrv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (s0 !== 3'd0 || f0 !== 1'b0 || c0 !== 8'd0) begin
      errors++;
      $display("FAIL reset_u0 got S=%0d F=%b CNT=%0d want 0 0 0", s0, f0, c0);
    end
    checks++;
    if (s1 !== 3'd0 || f1 !== 1'b0 || c1 !== 8'd0 || s2 !== 3'd0 || f2 !== 1'b0 || c2 !== 2'd0) begin
      errors++;
      $display("FAIL reset_u1u2 got S=%0d/%0d F=%b/%b CNT=%0d/%0d want zeros", s1, s2, f1, f2, c1, c2);
    end
  endtask

  task automatic test_stream();
    logic [6:0] bits = 7'b1011011;
    int exp_s0 [7] = '{1, 2, 3, 4, 2, 3, 4};
    int exp_s1 [7] = '{1, 2, 3, 4, 0, 1, 1};
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step(bits[6-i], 1'b1, 1'b0);
      checks++;
      if (int'(s0) != exp_s0[i] || f0 !== (exp_s0[i] == 4)) begin
        errors++;
        $display("FAIL overlap_bit%0d got S=%0d F=%b want S=%0d F=%b", i + 1, s0, f0, exp_s0[i], exp_s0[i] == 4);
      end
      checks++;
      if (int'(s1) != exp_s1[i] || f1 !== (exp_s1[i] == 4)) begin
        errors++;
        $display("FAIL nonoverlap_bit%0d got S=%0d F=%b want S=%0d F=%b", i + 1, s1, f1, exp_s1[i], exp_s1[i] == 4);
      end
    end
    checks++;
    if (c0 !== 8'd2) begin
      errors++;
      $display("FAIL overlap_cnt got %0d want 2", c0);
    end
    checks++;
    if (c1 !== 8'd1) begin
      errors++;
      $display("FAIL nonoverlap_cnt got %0d want 1", c1);
    end
  endtask

  task automatic test_enable_hold();
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(i[0] ? 1'b1 : 1'b0, 1'b0, 1'b0);
      checks++;
      if (s0 !== 3'd3 || f0 !== 1'b0 || c0 !== 8'd0) begin
        errors++;
        $display("FAIL en_hold_%0d got S=%0d F=%b CNT=%0d want 3 0 0", i, s0, f0, c0);
      end
    end
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (s0 !== 3'd4 || f0 !== 1'b1 || c0 !== 8'd1) begin
      errors++;
      $display("FAIL en_resume got S=%0d F=%b CNT=%0d want 4 1 1", s0, f0, c0);
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] first = 4'b1011;
    logic [2:0] tail  = 3'b011;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 3; i >= 0; i--) step(first[i], 1'b1, 1'b0);
    for (int m = 0; m < 4; m++)
      for (int i = 2; i >= 0; i--) step(tail[i], 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (s0 !== 3'd3 || c0 !== 8'd5) begin
      errors++;
      $display("FAIL pre_reset got S=%0d CNT=%0d want 3 5", s0, c0);
    end
    @(negedge clk);
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (s0 !== 3'd0 || f0 !== 1'b0 || c0 !== 8'd0) begin
      errors++;
      $display("FAIL async_reset got S=%0d F=%b CNT=%0d want 0 0 0", s0, f0, c0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (s0 !== 3'd1 || c0 !== 8'd0) begin
      errors++;
      $display("FAIL post_reset_first got S=%0d CNT=%0d want 1 0", s0, c0);
    end
  endtask

  task automatic test_saturate();
    int exp_c [5] = '{1, 2, 3, 3, 3};
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0);
      checks++;
      if (int'(c2) != exp_c[i] || f2 !== 1'b1 || s2 !== 3'd4) begin
        errors++;
        $display("FAIL saturate_%0d got CNT=%0d F=%b S=%0d want %0d 1 4", i, c2, f2, s2, exp_c[i]);
      end
    end
  endtask

  task automatic test_clr_on_complete();
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    checks++;
    if (s0 !== 3'd0 || f0 !== 1'b0 || c0 !== 8'd0) begin
      errors++;
      $display("FAIL clr_wins got S=%0d F=%b CNT=%0d want 0 0 0", s0, f0, c0);
    end
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (s0 !== 3'd1 || c0 !== 8'd0) begin
      errors++;
      $display("FAIL after_clr got S=%0d CNT=%0d want 1 0", s0, c0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    en    = 1'b0;
    x     = 1'b0;
    x2    = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_stream();
    test_enable_hold();
    test_async_reset();
    test_saturate();
    test_clr_on_complete();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_machine_seq

// File: doc/machine_seq.md
MACHINE_SEQ -- requirements
Module: machine_seq

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits, legal range 2..16.
REQ-002 Parameter PATTERN, default 4'b1011: target sequence, PAT_W bits; PATTERN[PAT_W-1] is the first bit received.
REQ-003 Parameter OVERLAP, default 1: 1 = overlapping detection, 0 = non-overlapping detection.
REQ-004 Parameter CNT_W, default 8: width of the match counter.
REQ-005 Derived constant SW = clog2(PAT_W+1) SHALL set the width of S; SW = 3 at defaults.
REQ-006 CLK  input  1  single clock; all state changes on its rising edge.
REQ-007 RESET_N  input  1  asynchronous, active-low reset.
REQ-008 CLR  input  1  synchronous clear of state and counter.
REQ-009 EN  input  1  sample enable; x is consumed only when EN=1.
REQ-010 x  input  1  serial data bit.
REQ-011 F  output  1  Moore match flag.
REQ-012 S  output  SW  current state, equal to the number of pattern bits currently matched.
REQ-013 CNT  output  CNT_W  saturating count of completed matches.

Function
REQ-014 State definition: S = length of the longest suffix of the consumed bits (since reset, CLR, or a non-overlap restart) that equals a prefix of PATTERN, range 0..PAT_W.
REQ-015 Next state uses KMP semantics: on an edge with EN=1, S_next = longest k <= PAT_W such that the last k bits of the history including x equal PATTERN's first k bits.
REQ-016 F SHALL be (S == PAT_W): Moore output, registered state only, no combinational path from x.
REQ-017 Latency: F asserts in the cycle after the edge that consumes the final pattern bit, and stays high exactly one cycle unless the next consumed bit completes another match.
REQ-018 OVERLAP=1, leaving state PAT_W: S_next is computed over the full history, so the matched bits remain usable.
REQ-019 OVERLAP=0, leaving state PAT_W: S_next is computed as if from state 0, with the history discarded.
REQ-020 EN=0: S, F and CNT hold; x is ignored.
REQ-021 CNT increments by 1 on each edge where EN=1 and S_next == PAT_W.
REQ-022 CNT saturates at 2^CNT_W-1 and SHALL NOT wrap.
REQ-023 CLR=1 at an edge forces S=0 and CNT=0 regardless of EN or x; CLR has priority over EN.
REQ-024 Simultaneous CLR and a completing bit: CLR wins, with no increment and F=0 next cycle.
REQ-025 PATTERN of all-equal bits (e.g. 1111) with OVERLAP=1: a sustained run of that bit SHALL keep F high every cycle after the first match.

Reset
REQ-026 RESET_N low SHALL immediately, without waiting for CLK, force S=0, F=0 and CNT=0, including mid-pattern or in state PAT_W.
REQ-027 After RESET_N rises, the first EN=1 edge SHALL consume a bit starting from state 0.
REQ-028 No output SHALL be X after the first RESET_N assertion.

Structure
REQ-029 Package machine_pkg SHALL hold the default PAT_W, PATTERN and CNT_W constants and a clog2-based state-width function shared with sibling machine_* blocks.
REQ-030 The saturating counter SHALL be a separate sub-module sat_counter (parameter W; inputs CLK, RESET_N, clr, inc; output q).
REQ-031 State register and next-state logic SHALL remain in machine_seq; next-state logic is a for-loop over candidate lengths against a PAT_W-bit history shift register.

Verification
REQ-032 Defaults, OVERLAP=1, EN=1, x = 1,0,1,1,0,1,1 -> S = 1,2,3,4,2,3,4; F high after bits 4 and 7; CNT=2.
REQ-033 Same stream with OVERLAP=0 -> S = 1,2,3,4,0,1,1; F high only after bit 4; CNT=1.
REQ-034 EN=0 held for 3 cycles after bits 1,0,1 while x toggles -> S stays 3; next EN=1 with x=1 -> S=4, F=1.
REQ-035 RESET_N pulsed low between edges while S=3 and CNT=5 -> S=0, F=0, CNT=0 before the next CLK edge.
REQ-036 CNT_W=2, five back-to-back matches of PATTERN 1111 with OVERLAP=1 -> CNT reads 1,2,3,3,3.
REQ-037 CLR=1 on the edge that consumes bit 4 of 1011 -> S=0, F=0, CNT unchanged at 0.
